shift_operand_seq: RTL and testbench

//  Multicycle operand-2 sequencer for the ARM data-processing datapath; sits directly upstream of the

---
 rtl/shift_operand_seq.sv | 198 +++++++++++++++++++
 tb/tb_shift_operand_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_seq.sv
// Operand-2 sequencer for the ARM data-processing datapath: decodes the shifter operand forms,
// drives an external 5-bit-amount shifter and applies edge-case fix-ups. Macro: SHOP_CARRY_EN.
module shift_operand_seq #(
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm_form,
  input  logic        reg_shift,
  input  logic [11:0] op2,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic        carry_in,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_shamt,
  output logic [1:0]  sh_shtype,
  input  logic [31:0] sh_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0] dec_a;
  logic [1:0]  dec_type;
  logic [7:0]  dec_amt;
  logic        dec_rrx;
  logic        dec_fast;
  logic        accept;

  logic [31:0] sh_a_q;
  logic [4:0]  sh_shamt_q;
  logic [1:0]  sh_shtype_q;
  logic [7:0]  amt_q;
  logic        rrx_q;
  logic        cin_q;
  logic [31:0] result_q;
  logic [31:0] shift_res;

  // Only the low byte of Rs participates in a register-specified shift.
  logic unused_rs;
  assign unused_rs = ^rs_val[31:8];

  // Operand decode, evaluated combinationally from the request fields.
  always_comb begin
    dec_a    = rm_val;
    dec_type = op2[6:5];
    dec_amt  = 8'd0;
    dec_rrx  = 1'b0;
    if (imm_form) begin
      dec_a    = {24'd0, op2[7:0]};
      dec_type = ShRor;
      dec_amt  = {3'd0, op2[11:8], 1'b0};
    end else if (reg_shift) begin
      dec_amt = rs_val[7:0];
    end else begin
      dec_amt = {3'd0, op2[11:7]};
      // Immediate #0 encodes LSR/ASR #32 and RRX.
      if (op2[11:7] == 5'd0) begin
        unique case (op2[6:5])
          ShLsr, ShAsr: dec_amt = 8'd32;
          ShRor:        dec_rrx = 1'b1;
          default:      ;
        endcase
      end
    end
  end

  assign dec_fast = FAST_ZERO && (dec_amt == 8'd0) && !dec_rrx;
  assign accept   = in_valid && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dec_fast ? StDone : StShift;
      end
      StShift: state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Result fix-ups for cases the 5-bit shifter cannot express.
  always_comb begin
    shift_res = sh_y;
    if (rrx_q) begin
      shift_res = {cin_q, sh_a_q[31:1]};
    end else if (amt_q == 8'd0) begin
      shift_res = sh_a_q;
    end else begin
      unique case (sh_shtype_q)
        ShLsl, ShLsr: if (amt_q >= 8'd32) shift_res = 32'd0;
        ShAsr:        if (amt_q >= 8'd32) shift_res = {32{sh_a_q[31]}};
        ShRor:        if (amt_q[4:0] == 5'd0) shift_res = sh_a_q;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_a_q      <= 32'd0;
      sh_shamt_q  <= 5'd0;
      sh_shtype_q <= 2'd0;
      amt_q       <= 8'd0;
      rrx_q       <= 1'b0;
      cin_q       <= 1'b0;
      result_q    <= 32'd0;
    end else if (accept) begin
      cin_q <= carry_in;
      if (dec_fast) begin
        result_q <= dec_a;
      end else begin
        // Shifter inputs stay frozen until the next slow-path accept.
        sh_a_q      <= dec_a;
        sh_shamt_q  <= dec_amt[4:0];
        sh_shtype_q <= dec_type;
        amt_q       <= dec_amt;
        rrx_q       <= dec_rrx;
      end
    end else if (state_q == StShift) begin
      result_q <= shift_res;
    end
  end

  assign sh_a      = sh_a_q;
  assign sh_shamt  = sh_shamt_q;
  assign sh_shtype = sh_shtype_q;
  assign result    = result_q;

`ifdef SHOP_CARRY_EN
  logic       carry_q;
  logic       shift_c;
  logic [4:0] lsl_idx;
  logic [4:0] lsr_idx;

  // For LSL by n the carry is a[32-n]; 32-n equals -n modulo 32.
  assign lsl_idx = ~amt_q[4:0] + 5'd1;
  assign lsr_idx = amt_q[4:0] - 5'd1;

  always_comb begin
    shift_c = cin_q;
    if (rrx_q) begin
      shift_c = sh_a_q[0];
    end else if (amt_q != 8'd0) begin
      unique case (sh_shtype_q)
        ShLsl: begin
          if (amt_q < 8'd32)       shift_c = sh_a_q[lsl_idx];
          else if (amt_q == 8'd32) shift_c = sh_a_q[0];
          else                     shift_c = 1'b0;
        end
        ShLsr: begin
          if (amt_q < 8'd32)       shift_c = sh_a_q[lsr_idx];
          else if (amt_q == 8'd32) shift_c = sh_a_q[31];
          else                     shift_c = 1'b0;
        end
        ShAsr: shift_c = (amt_q < 8'd32) ? sh_a_q[lsr_idx] : sh_a_q[31];
        ShRor: shift_c = (amt_q[4:0] == 5'd0) ? sh_a_q[31] : sh_y[31];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     carry_q <= 1'b0;
    else if (accept && dec_fast)      carry_q <= carry_in;
    else if (state_q == StShift)      carry_q <= shift_c;
  end

  assign carry_out = carry_q;
`else
  assign carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_shift_operand_seq.sv
// Self-checking bench for shift_operand_seq: directed corner cases, randomized operands against
// a wide-arithmetic reference model, DONE stall, and mid-operation reset.
module tb_shift_operand_seq;

`ifdef SHOP_CARRY_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        imm_form;
  logic        reg_shift;
  logic [11:0] op2;
  logic [31:0] rm_val;
  logic [31:0] rs_val;
  logic        carry_in;
  logic [31:0] sh_a;
  logic [4:0]  sh_shamt;
  logic [1:0]  sh_shtype;
  logic [31:0] sh_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;

  int passed;
  int total;

  shift_operand_seq #(.FAST_ZERO(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_form  (imm_form),
    .reg_shift (reg_shift),
    .op2       (op2),
    .rm_val    (rm_val),
    .rs_val    (rs_val),
    .carry_in  (carry_in),
    .sh_a      (sh_a),
    .sh_shamt  (sh_shamt),
    .sh_shtype (sh_shtype),
    .sh_y      (sh_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment: a plain barrel shifter with a 5-bit amount.
  function automatic logic [31:0] shifter(input logic [31:0] a, input logic [4:0] n,
                                          input logic [1:0] t);
    logic [63:0] w;
    logic signed [31:0] s;
    s = a;
    w = {a, a} >> n;
    case (t)
      2'd0:    return a << n;
      2'd1:    return a >> n;
      2'd2:    return s >>> n;
      default: return w[31:0];
    endcase
  endfunction

  always_comb sh_y = shifter(sh_a, sh_shamt, sh_shtype);

  // Reference: full-width arithmetic shifts, no 5-bit limitation.
  function automatic void model(input logic imm, input logic regs, input logic [11:0] o,
                                input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                                output logic [31:0] res, output logic c, output int lat);
    logic [31:0] a;
    int t;
    int n;
    bit rrx;
    logic [63:0] w;
    logic signed [63:0] sw;
    rrx = 1'b0;
    a = rm;
    t = int'(o[6:5]);
    if (imm) begin
      a = {24'd0, o[7:0]};
      t = 3;
      n = 2 * int'(o[11:8]);
    end else if (regs) begin
      n = int'(rs[7:0]);
    end else begin
      n = int'(o[11:7]);
      if (n == 0 && t == 3) rrx = 1'b1;
      else if (n == 0 && t != 0) n = 32;
    end
    if (rrx) begin
      res = {cin, a[31:1]};
      c = a[0];
    end else if (n == 0) begin
      res = a;
      c = cin;
    end else begin
      case (t)
        0: begin w = {32'd0, a} << n; res = w[31:0]; c = w[32]; end
        1: begin w = {a, 32'd0} >> n; res = w[63:32]; c = w[31]; end
        2: begin sw = {a, 32'd0}; sw = sw >>> n; res = sw[63:32]; c = sw[31]; end
        default: begin w = {a, a} >> (n % 32); res = w[31:0]; c = res[31]; end
      endcase
    end
    lat = (!rrx && n == 0) ? 1 : 2;
    if (!CarryEn) c = 1'b0;
  endfunction

  // Issues one request, scrambles inputs after accept, returns the observed outcome.
  task automatic do_op(input logic imm, input logic regs, input logic [11:0] o,
                       input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                       output logic [31:0] res, output logic c, output int lat,
                       output logic rdy);
    @(negedge clk);
    rdy       = in_ready;
    imm_form  = imm;
    reg_shift = regs;
    op2       = o;
    rm_val    = rm;
    rs_val    = rs;
    carry_in  = cin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    imm_form  = 1'($urandom);
    reg_shift = 1'($urandom);
    op2       = 12'($urandom);
    rm_val    = $urandom;
    rs_val    = $urandom;
    carry_in  = ~cin;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    c   = carry_out;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imm_form  = 1'b0;
    reg_shift = 1'b0;
    op2       = 12'd0;
    rm_val    = 32'd0;
    rs_val    = 32'd0;
    carry_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_handshake: got %b, want 10", {in_ready, out_valid});
    else passed++;
    total++;
    if ({result, carry_out} !== 33'd0)
      $display("FAIL reset_result: got %h/%b, want 0/0", result, carry_out);
    else passed++;
    total++;
    if ({sh_a, sh_shamt, sh_shtype} !== 39'd0)
      $display("FAIL reset_shifter: got %h/%h/%h, want 0", sh_a, sh_shamt, sh_shtype);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] r;
    logic c;
    int lat;
    logic rdy;
    logic [31:0] v_rm [6] = '{32'h0, 32'h80000001, 32'h80000000, 32'hFFFFFFFF,
                              32'h00000003, 32'hDEADBEEF};
    logic [31:0] v_rs [6] = '{32'h0, 32'h0, 32'h28, 32'h21, 32'h0, 32'h0};
    logic [11:0] v_op [6] = '{12'h4FF, 12'h020, 12'h050, 12'h010, 12'h060, 12'h010};
    logic        v_imm[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_rg [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        v_ci [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_r  [6] = '{32'hFF000000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h80000001,
                              32'hDEADBEEF};
    logic        e_c  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          e_l  [6] = '{2, 2, 2, 2, 2, 1};
    for (int i = 0; i < 6; i++) begin
      do_op(v_imm[i], v_rg[i], v_op[i], v_rm[i], v_rs[i], v_ci[i], r, c, lat, rdy);
      total++;
      if (rdy !== 1'b1) $display("FAIL dir%0d_in_ready: got %b, want 1", i, rdy);
      else passed++;
      total++;
      if (lat !== e_l[i]) $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, e_l[i]);
      else passed++;
      total++;
      if (r !== e_r[i]) $display("FAIL dir%0d_result: got %h, want %h", i, r, e_r[i]);
      else passed++;
      total++;
      if (c !== (e_c[i] & CarryEn))
        $display("FAIL dir%0d_carry: got %b, want %b", i, c, e_c[i] & CarryEn);
      else passed++;
    end
  endtask

  task automatic test_random;
    logic [31:0] r, er, rm, rs;
    logic c, ec, imm, regs, cin, rdy;
    logic [11:0] o;
    int lat, el;
    for (int i = 0; i < 200; i++) begin
      imm  = ($urandom_range(0, 3) == 0);
      regs = 1'($urandom);
      o    = 12'($urandom);
      if ($urandom_range(0, 3) == 0) o[11:7] = 5'd0;
      rm   = $urandom;
      rs   = $urandom;
      if ($urandom_range(0, 2) != 0) rs[7:0] = 8'($urandom_range(0, 40));
      cin  = 1'($urandom);
      o[4] = regs;
      model(imm, regs, o, rm, rs, cin, er, ec, el);
      do_op(imm, regs, o, rm, rs, cin, r, c, lat, rdy);
      total++;
      if (lat !== el || rdy !== 1'b1)
        $display("FAIL rnd%0d_timing: got lat %0d rdy %b, want lat %0d rdy 1", i, lat, rdy, el);
      else passed++;
      total++;
      if (r !== er || c !== ec)
        $display("FAIL rnd%0d_value op2=%h rm=%h rs=%h: got %h/%b, want %h/%b",
                 i, o, rm, rs, r, c, er, ec);
      else passed++;
    end
  endtask

  task automatic test_stall;
    logic [31:0] er;
    logic ec;
    int el;
    int wait_cyc;
    model(1'b0, 1'b1, 12'h030, 32'h12345678, 32'h4, 1'b0, er, ec, el);
    @(negedge clk);
    imm_form = 1'b0; reg_shift = 1'b1; op2 = 12'h030;
    rm_val = 32'h12345678; rs_val = 32'h4; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Keep a second request pending with different data; it must not be taken in DONE.
    op2 = 12'h010; rm_val = 32'hA5A5A5A5; rs_val = 32'h1;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 8) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({out_valid, in_ready} !== 2'b10 || result !== er || carry_out !== ec)
        $display("FAIL stall%0d: got v%b r%b %h/%b, want v1 r0 %h/%b",
                 k, out_valid, in_ready, result, carry_out, er, ec);
      else passed++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL stall_bubble: got ready %b valid %b, want 1 0", in_ready, out_valid);
    else passed++;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL stall_idle: got ready %b valid %b, want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int rises;
    @(negedge clk);
    imm_form = 1'b1; reg_shift = 1'b0; op2 = 12'h4FF; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b00)
      $display("FAIL rstmid_shift: got ready %b valid %b, want 0 0", in_ready, out_valid);
    else passed++;
    reset_n = 1'b0;
    #1;
    rises = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) rises++;
    end
    total++;
    if (rises !== 0 || in_ready !== 1'b1 || result !== 32'd0)
      $display("FAIL rstmid_abort: got %0d valid cycles ready %b result %h, want 0 1 0",
               rises, in_ready, result);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
